// File: rtl/p_mul.sv
// Iterative packed-lane multiplier: each cycle adds (or XORs) one shifted
// multiplicand per lane into a shared 64-bit accumulator.
module p_mul (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid,
  output logic        ready,
  input  logic        mul_l,
  input  logic        mul_h,
  input  logic        clmul,
  input  logic [4:0]  pw,
  input  logic [31:0] crs1,
  input  logic [31:0] crs2,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e      state_q, state_d;
  logic [63:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  wIdx;
  logic [4:0]  wLast;
  logic [63:0] addSel;
  logic [63:0] addend [5];

  always_comb begin
    wIdx  = 3'd0;
    wLast = 5'd31;
    if      (pw[0]) begin wIdx = 3'd0; wLast = 5'd31; end
    else if (pw[1]) begin wIdx = 3'd1; wLast = 5'd15; end
    else if (pw[2]) begin wIdx = 3'd2; wLast = 5'd7;  end
    else if (pw[3]) begin wIdx = 3'd3; wLast = 5'd3;  end
    else if (pw[4]) begin wIdx = 3'd4; wLast = 5'd1;  end
  end

  // Partial products never exceed the final lane product, so a plain 64-bit
  // add cannot carry across a lane boundary.
  for (genvar k = 0; k < 5; k++) begin : g_width
    localparam int W = 32 >> k;
    localparam int N = 32 / W;
    logic [4:0] cntLane;
    assign cntLane = cnt_q & 5'(W - 1);
    always_comb begin
      addend[k] = '0;
      for (int i = 0; i < N; i++) begin
        if (crs2[W*i + int'(cntLane)])
          addend[k][2*W*i +: 2*W] = {{W{1'b0}}, crs1[W*i +: W]} << cntLane;
      end
    end
  end

  always_comb begin
    case (wIdx)
      3'd1:    addSel = addend[1];
      3'd2:    addSel = addend[2];
      3'd3:    addSel = addend[3];
      3'd4:    addSel = addend[4];
      default: addSel = addend[0];
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid) state_d = BUSY;
      BUSY: begin
        if (!valid)              state_d = IDLE;
        else if (cnt_q == wLast) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: begin
        if (valid) begin
          acc_d = '0;
          cnt_d = '0;
        end
      end
      BUSY: begin
        if (valid) begin
          acc_d = clmul ? (acc_q ^ addSel) : (acc_q + addSel);
          cnt_d = cnt_q + 5'd1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    ready  = (state_q == DONE);
    result = '0;
    if (mul_l)      result = acc_q[31:0];
    else if (mul_h) result = acc_q[63:32];
  end

endmodule

// File: tb/tb_p_mul.sv
// Directed and random scoreboard bench for the packed-lane multiplier.
module tb_p_mul;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid;
  logic        ready;
  logic        mul_l;
  logic        mul_h;
  logic        clmul;
  logic [4:0]  pw;
  logic [31:0] crs1;
  logic [31:0] crs2;
  logic [31:0] result;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] sbQueue [$];

  p_mul dut (
    .clock(clock), .reset(reset), .valid(valid), .ready(ready),
    .mul_l(mul_l), .mul_h(mul_h), .clmul(clmul), .pw(pw),
    .crs1(crs1), .crs2(crs2), .result(result)
  );

  always #5 clock = ~clock;

  function automatic int widthOf(input logic [4:0] p);
    if (p[0]) return 32;
    if (p[1]) return 16;
    if (p[2]) return 8;
    if (p[3]) return 4;
    if (p[4]) return 2;
    return 32;
  endfunction

  function automatic logic [63:0] refAcc(input logic [31:0] a, input logic [31:0] b,
                                         input logic [4:0] p, input logic cl);
    int w;
    logic [63:0] acc, pa, pb, prod, mask;
    w    = widthOf(p);
    acc  = '0;
    mask = (64'd1 << w) - 64'd1;
    for (int i = 0; i < 32 / w; i++) begin
      pa = (64'(a) >> (w * i)) & mask;
      pb = (64'(b) >> (w * i)) & mask;
      if (!cl) prod = pa * pb;
      else begin
        prod = '0;
        for (int j = 0; j < w; j++) if (pb[j]) prod = prod ^ (pa << j);
      end
      acc = acc | (prod << (2 * w * i));
    end
    return acc;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] p, input logic cl);
    crs1  = a;
    crs2  = b;
    pw    = p;
    clmul = cl;
    valid = 1'b1;
    sbQueue.push_back(refAcc(a, b, p, cl));
  endtask

  // Counts rising edges until ready is seen, at most maxEdges.
  task automatic waitReady(input int maxEdges, output int lat, output bit seen);
    lat  = 0;
    seen = 1'b0;
    for (int k = 0; k < maxEdges && !seen; k++) begin
      @(posedge clock); #1;
      lat++;
      if (ready) seen = 1'b1;
    end
  endtask

  // Called just after the edge that raised ready; exercises both selects.
  task automatic checkHalves(input string tag);
    logic [63:0] exp;
    if (sbQueue.size() == 0) begin
      checkOutput({tag, "_sbEmpty"}, 64'd1, 64'd0);
      return;
    end
    exp   = sbQueue.pop_front();
    mul_l = 1'b1; mul_h = 1'b0; #1;
    checkOutput({tag, "_lo"}, 64'(result), 64'(exp[31:0]));
    mul_l = 1'b0; mul_h = 1'b1; #1;
    checkOutput({tag, "_hi"}, 64'(result), 64'(exp[63:32]));
    mul_l = 1'b0; mul_h = 1'b0; #1;
    checkOutput({tag, "_none"}, 64'(result), 64'd0);
  endtask

  task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] p, input logic cl);
    int lat;
    bit seen;
    applyStimulus(a, b, p, cl);
    waitReady(40, lat, seen);
    checkOutput({tag, "_ready"}, 64'(seen), 64'd1);
    checkOutput({tag, "_latency"}, 64'(lat), 64'(widthOf(p) + 1));
    if (seen) checkHalves(tag);
    valid = 1'b0;
    @(posedge clock); #1;
    checkOutput({tag, "_readyOneCycle"}, 64'(ready), 64'd0);
  endtask

  initial begin
    int lat, readyHits, cyc, w, abortAt;
    bit seen;
    logic [63:0] exp;

    reset = 1'b1; valid = 1'b0; mul_l = 1'b0; mul_h = 1'b0;
    clmul = 1'b0; pw = 5'b00001; crs1 = '0; crs2 = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    checkOutput("reset_ready", 64'(ready), 64'd0);
    mul_l = 1'b1; #1;
    checkOutput("reset_accLo", 64'(result), 64'd0);
    mul_l = 1'b0; mul_h = 1'b1; #1;
    checkOutput("reset_accHi", 64'(result), 64'd0);
    mul_h = 1'b0;

    runOp("w32_allOnes", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'b00001, 1'b0);
    runOp("w16_lanes",   32'h0003_0002, 32'h0005_0007, 5'b00010, 1'b0);
    runOp("w8_lanes",    32'h0102_0304, 32'h0202_0202, 5'b00100, 1'b0);
    runOp("clmul_3x3",   32'd3,         32'd3,         5'b00001, 1'b1);
    runOp("w4_lanes",    32'hFEDC_BA98, 32'h1234_5678, 5'b01000, 1'b0);
    runOp("w2_clmul",    32'hA5A5_F00F, 32'h3C3C_FFFF, 5'b10000, 1'b1);
    runOp("pw_zero",     32'h1234_5678, 32'h9ABC_DEF0, 5'b00000, 1'b0);
    runOp("pw_priority", 32'h00FF_00FF, 32'h00FF_0002, 5'b10110, 1'b0);

    // Back-to-back: valid held across the ready cycle with new operands.
    applyStimulus(32'h0000_1234, 32'h0000_5678, 5'b00010, 1'b0);
    waitReady(40, lat, seen);
    checkOutput("b2b_first_ready", 64'(seen), 64'd1);
    if (seen) checkHalves("b2b_first");
    applyStimulus(32'h0011_0022, 32'h0033_0044, 5'b00100, 1'b0);
    waitReady(40, lat, seen);
    checkOutput("b2b_second_ready", 64'(seen), 64'd1);
    checkOutput("b2b_second_latency", 64'(lat), 64'(8 + 2));
    if (seen) checkHalves("b2b_second");
    valid = 1'b0;
    @(posedge clock); #1;

    // Reset during BUSY discards the operation.
    crs1 = 32'hDEAD_BEEF; crs2 = 32'h1234_5678; pw = 5'b00001; clmul = 1'b0;
    valid = 1'b1;
    readyHits = 0;
    repeat (6) begin
      @(posedge clock); #1;
      if (ready) readyHits++;
    end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    valid = 1'b0;
    repeat (40) begin
      @(posedge clock); #1;
      if (ready) readyHits++;
    end
    checkOutput("resetMid_noReady", 64'(readyHits), 64'd0);
    runOp("afterReset", 32'hDEAD_BEEF, 32'h1234_5678, 5'b00001, 1'b0);

    // Dropping valid while BUSY aborts without a ready pulse.
    crs1 = 32'h0000_FFFF; crs2 = 32'h0000_FFFF; pw = 5'b00010;
    valid = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    valid = 1'b0;
    readyHits = 0;
    repeat (30) begin
      @(posedge clock); #1;
      if (ready) readyHits++;
    end
    checkOutput("abort_noReady", 64'(readyHits), 64'd0);

    // Random soak with occasional aborts.
    cyc = 0;
    while (cyc < 10000) begin
      valid = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clock); #1; cyc++;
      end
      pw = ($urandom_range(0, 1) == 0) ? 5'b00001 : 5'b00010;
      w  = widthOf(pw);
      if ($urandom_range(0, 7) == 0) begin
        crs1 = $urandom; crs2 = $urandom; clmul = 1'b0; valid = 1'b1;
        abortAt = $urandom_range(1, w);
        repeat (abortAt) begin
          @(posedge clock); #1; cyc++;
        end
        valid = 1'b0;
        readyHits = 0;
        repeat (3) begin
          @(posedge clock); #1; cyc++;
          if (ready) readyHits++;
        end
        checkOutput("soak_abort", 64'(readyHits), 64'd0);
      end else begin
        applyStimulus($urandom, $urandom, pw, 1'b0);
        waitReady(40, lat, seen);
        cyc += lat;
        checkOutput("soak_ready", 64'(seen), 64'd1);
        if (seen && sbQueue.size() > 0) begin
          exp   = sbQueue.pop_front();
          mul_l = 1'($urandom_range(0, 1));
          mul_h = 1'($urandom_range(0, 1));
          #1;
          checkOutput("soak_result", 64'(result),
                      mul_l ? 64'(exp[31:0]) : (mul_h ? 64'(exp[63:32]) : 64'd0));
          mul_l = 1'b0; mul_h = 1'b0;
        end
      end
    end
    valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
